// File: rtl/ecc_queued_engine.sv
`default_nettype none
// ==========================================================================
// ecc_queued_engine : APB-programmed SECDED encode/decode engine with
//                     job FIFO, result FIFO, PSLVERR and interrupt.
// Revision 1.0
// ==========================================================================
module ecc_queued_engine #(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int DATA_WIDTH      = 32,
  parameter int JOB_DEPTH       = 4,
  parameter int RES_DEPTH       = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [AMBA_WORD-1:0]       PWDATA,
  output logic [AMBA_WORD-1:0]       PRDATA,
  output logic                       PREADY,
  output logic                       PSLVERR,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       operation_done,
  output logic [1:0]                 num_of_errors,
  output logic                       irq
);

  localparam int c_JAW = $clog2(JOB_DEPTH);
  localparam int c_RAW = $clog2(RES_DEPTH);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_EXEC = 2'd1;
  localparam logic [1:0] c_DEC  = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  // Highest Hamming position (n-1) for each codeword width code.
  function automatic int f_np(input logic [1:0] w);
    return (w == 2'd0) ? 7 : (w == 2'd1) ? 15 : 31;
  endfunction

  function automatic logic [31:0] f_mask(input logic [1:0] w);
    return (w == 2'd0) ? 32'h0000_00FF : (w == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] f_encode(input logic [25:0] d, input logic [1:0] w);
    logic [31:0] cw;
    logic [4:0]  syn;
    int          k;
    int          np;
    np  = f_np(w);
    cw  = '0;
    syn = '0;
    k   = 0;
    for (int p = 1; p < 32; p++) begin
      if (p <= np && (p & (p - 1)) != 0) begin
        cw[p-1] = d[k];
        if (d[k]) syn = syn ^ 5'(p);
        k = k + 1;
      end
    end
    for (int i = 0; i < 5; i++)
      if ((1 << i) <= np) cw[(1 << i) - 1] = syn[i];
    cw[np] = ^cw;
    return cw;
  endfunction

  // Returns {num_of_errors, extracted data}; input must already be masked to n bits.
  function automatic logic [27:0] f_decode(input logic [31:0] cw_in, input logic [1:0] w);
    logic [31:0] cw;
    logic [4:0]  syn;
    logic [25:0] d;
    logic [1:0]  err;
    int          k;
    int          np;
    np  = f_np(w);
    cw  = cw_in;
    syn = '0;
    d   = '0;
    err = 2'd0;
    k   = 0;
    for (int p = 1; p < 32; p++)
      if (p <= np && cw[p-1]) syn = syn ^ 5'(p);
    if (^cw) begin
      err = 2'd1;
      if (syn == 5'd0) cw[np] = ~cw[np];
      else             cw[syn - 5'd1] = ~cw[syn - 5'd1];
    end else if (syn != 5'd0) begin
      err = 2'd2;
    end
    for (int p = 1; p < 32; p++) begin
      if (p <= np && (p & (p - 1)) != 0) begin
        d[k] = cw[p-1];
        k = k + 1;
      end
    end
    return {err, d};
  endfunction

  logic [AMBA_WORD-1:0] r_data_in;
  logic [1:0]           r_width;
  logic [AMBA_WORD-1:0] r_noise;
  logic                 r_irq_en;
  logic                 r_irq_pend;

  logic [1:0]           r_job_mode  [JOB_DEPTH];
  logic [1:0]           r_job_width [JOB_DEPTH];
  logic [AMBA_WORD-1:0] r_job_data  [JOB_DEPTH];
  logic [AMBA_WORD-1:0] r_job_noise [JOB_DEPTH];
  logic [c_JAW-1:0]     r_job_wp;
  logic [c_JAW-1:0]     r_job_rp;
  logic [3:0]           r_job_cnt;

  logic [31:0]          r_res_data [RES_DEPTH];
  logic [1:0]           r_res_err  [RES_DEPTH];
  logic [c_RAW-1:0]     r_res_wp;
  logic [c_RAW-1:0]     r_res_rp;
  logic [3:0]           r_res_cnt;

  logic [1:0]           r_state;
  logic [1:0]           r_cur_mode;
  logic [1:0]           r_cur_width;
  logic [AMBA_WORD-1:0] r_cur_data;
  logic [AMBA_WORD-1:0] r_cur_noise;
  logic [31:0]          r_cw;
  logic [31:0]          r_dec_data;
  logic [1:0]           r_dec_err;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic [1:0]           r_nerr;
  logic                 r_op_done;

  logic                 w_acc, w_wr, w_rd, w_aligned;
  logic [2:0]           w_reg;
  logic                 w_job_full, w_job_empty, w_res_full, w_res_empty;
  logic                 w_ctrl_wr, w_ctrl_bad, w_job_push, w_job_pop;
  logic                 w_res_rd, w_res_pop, w_res_push, w_irq_w1c, w_busy;
  logic [31:0]          w_status;
  logic [27:0]          w_dec;
  logic                 w_unused_paddr;

  assign w_acc       = PSEL & PENABLE;
  assign w_wr        = w_acc & PWRITE;
  assign w_rd        = w_acc & ~PWRITE;
  assign w_aligned   = (PADDR[1:0] == 2'b00);
  assign w_reg       = PADDR[4:2];
  assign w_unused_paddr = ^PADDR[AMBA_ADDR_WIDTH-1:5];

  assign w_job_full  = (r_job_cnt == 4'(JOB_DEPTH));
  assign w_job_empty = (r_job_cnt == 4'd0);
  assign w_res_full  = (r_res_cnt == 4'(RES_DEPTH));
  assign w_res_empty = (r_res_cnt == 4'd0);
  assign w_busy      = (r_state != c_IDLE);

  // Full check uses the registered count, so a same-cycle pop does not make room.
  assign w_ctrl_wr   = w_wr & w_aligned & (w_reg == 3'd0);
  assign w_ctrl_bad  = (PWDATA[1:0] == 2'd3) | (r_width == 2'd3) | w_job_full;
  assign w_job_push  = w_ctrl_wr & ~w_ctrl_bad;
  assign w_job_pop   = (r_state == c_IDLE) & ~w_job_empty & ~w_res_full;

  assign w_res_rd    = w_rd & w_aligned & (w_reg == 3'd5);
  assign w_res_pop   = w_res_rd & ~w_res_empty;
  assign w_res_push  = (r_state == c_DONE);
  assign w_irq_w1c   = w_wr & w_aligned & (w_reg == 3'd7) & PWDATA[1];

  assign w_status = {12'b0, r_res_cnt, 4'b0, r_job_cnt, 3'b0,
                     r_irq_pend, ~w_res_empty, w_job_empty, w_job_full, w_busy};

  assign PREADY  = 1'b1;
  assign PSLVERR = w_acc & (~w_aligned | (w_ctrl_wr & w_ctrl_bad) | (w_res_rd & w_res_empty));

  always_comb begin
    PRDATA = '0;
    if (w_rd && w_aligned) begin
      case (w_reg)
        3'd1:    PRDATA = r_data_in;
        3'd2:    PRDATA = AMBA_WORD'(r_width);
        3'd3:    PRDATA = r_noise;
        3'd4:    PRDATA = AMBA_WORD'(w_status);
        3'd5:    PRDATA = w_res_empty ? '0 : AMBA_WORD'(r_res_data[r_res_rp]);
        3'd6:    PRDATA = w_res_empty ? '0 : AMBA_WORD'(r_res_err[r_res_rp]);
        3'd7:    PRDATA = AMBA_WORD'({r_irq_pend, r_irq_en});
        default: PRDATA = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data_in  <= '0;
      r_width    <= '0;
      r_noise    <= '0;
      r_irq_en   <= 1'b0;
      r_irq_pend <= 1'b0;
    end else begin
      if (w_wr && w_aligned) begin
        case (w_reg)
          3'd1:    r_data_in <= PWDATA;
          3'd2:    r_width   <= PWDATA[1:0];
          3'd3:    r_noise   <= PWDATA;
          3'd7:    r_irq_en  <= PWDATA[0];
          default: ;
        endcase
      end
      // A completion in the same cycle as the clear keeps the interrupt pending.
      if (w_res_push && r_irq_en) r_irq_pend <= 1'b1;
      else if (w_irq_w1c)         r_irq_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < JOB_DEPTH; i++) begin
        r_job_mode[i]  <= '0;
        r_job_width[i] <= '0;
        r_job_data[i]  <= '0;
        r_job_noise[i] <= '0;
      end
      r_job_wp  <= '0;
      r_job_rp  <= '0;
      r_job_cnt <= '0;
    end else begin
      if (w_job_push) begin
        r_job_mode[r_job_wp]  <= PWDATA[1:0];
        r_job_width[r_job_wp] <= r_width;
        r_job_data[r_job_wp]  <= r_data_in;
        r_job_noise[r_job_wp] <= r_noise;
        r_job_wp              <= r_job_wp + c_JAW'(1);
      end
      if (w_job_pop) r_job_rp <= r_job_rp + c_JAW'(1);
      r_job_cnt <= r_job_cnt + {3'b0, w_job_push} - {3'b0, w_job_pop};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RES_DEPTH; i++) begin
        r_res_data[i] <= '0;
        r_res_err[i]  <= '0;
      end
      r_res_wp  <= '0;
      r_res_rp  <= '0;
      r_res_cnt <= '0;
    end else begin
      if (w_res_push) begin
        r_res_data[r_res_wp] <= r_dec_data;
        r_res_err[r_res_wp]  <= r_dec_err;
        r_res_wp             <= r_res_wp + c_RAW'(1);
      end
      if (w_res_pop) r_res_rp <= r_res_rp + c_RAW'(1);
      r_res_cnt <= r_res_cnt + {3'b0, w_res_push} - {3'b0, w_res_pop};
    end
  end

  assign w_dec = f_decode(r_cw, r_cur_width);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= c_IDLE;
      r_cur_mode  <= '0;
      r_cur_width <= '0;
      r_cur_data  <= '0;
      r_cur_noise <= '0;
      r_cw        <= '0;
      r_dec_data  <= '0;
      r_dec_err   <= '0;
      r_data_out  <= '0;
      r_nerr      <= '0;
      r_op_done   <= 1'b0;
    end else begin
      r_op_done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (w_job_pop) begin
            r_cur_mode  <= r_job_mode[r_job_rp];
            r_cur_width <= r_job_width[r_job_rp];
            r_cur_data  <= r_job_data[r_job_rp];
            r_cur_noise <= r_job_noise[r_job_rp];
            r_state     <= c_EXEC;
          end
        end
        c_EXEC: begin
          if (r_cur_mode == 2'd1)
            r_cw <= r_cur_data[31:0] & f_mask(r_cur_width);
          else if (r_cur_mode == 2'd2)
            r_cw <= f_encode(r_cur_data[25:0], r_cur_width) ^ (r_cur_noise[31:0] & f_mask(r_cur_width));
          else
            r_cw <= f_encode(r_cur_data[25:0], r_cur_width);
          r_state <= c_DEC;
        end
        c_DEC: begin
          if (r_cur_mode == 2'd0) begin
            r_dec_data <= r_cw;
            r_dec_err  <= 2'd0;
          end else begin
            r_dec_data <= {6'b0, w_dec[25:0]};
            r_dec_err  <= w_dec[27:26];
          end
          r_state <= c_DONE;
        end
        default: begin
          r_data_out <= DATA_WIDTH'(r_dec_data);
          r_nerr     <= r_dec_err;
          r_op_done  <= 1'b1;
          r_state    <= c_IDLE;
        end
      endcase
    end
  end

  assign data_out       = r_data_out;
  assign num_of_errors  = r_nerr;
  assign operation_done = r_op_done;
  assign irq            = r_irq_pend & r_irq_en;

endmodule
`default_nettype wire

// File: tb/tb_ecc_queued_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ==========================================================================
// tb_ecc_queued_engine : directed self-checking bench for ecc_queued_engine.
// Revision 1.0
// ==========================================================================
module tb_ecc_queued_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [19:0] r_paddr = '0;
  logic        r_psel = 1'b0;
  logic        r_penable = 1'b0;
  logic        r_pwrite = 1'b0;
  logic [31:0] r_pwdata = '0;
  logic [31:0] w_prdata;
  logic        w_pready;
  logic        w_pslverr;
  logic [31:0] w_data_out;
  logic        w_op_done;
  logic [1:0]  w_nerr;
  logic        w_irq;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int last_wr_cyc = 0;

  ecc_queued_engine #(
    .AMBA_WORD(32), .AMBA_ADDR_WIDTH(20), .DATA_WIDTH(32), .JOB_DEPTH(4), .RES_DEPTH(4)
  ) u_dut (
    .clk            (clk),
    .reset          (reset),
    .PADDR          (r_paddr),
    .PSEL           (r_psel),
    .PENABLE        (r_penable),
    .PWRITE         (r_pwrite),
    .PWDATA         (r_pwdata),
    .PRDATA         (w_prdata),
    .PREADY         (w_pready),
    .PSLVERR        (w_pslverr),
    .data_out       (w_data_out),
    .operation_done (w_op_done),
    .num_of_errors  (w_nerr),
    .irq            (w_irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  // All APB tasks start and end on a falling edge.
  task automatic apb_wr(input logic [4:0] a, input logic [31:0] d, output logic err);
    r_paddr = {15'b0, a}; r_pwrite = 1'b1; r_pwdata = d; r_psel = 1'b1; r_penable = 1'b0;
    @(negedge clk);
    r_penable = 1'b1;
    #1 err = w_pslverr;
    @(posedge clk);
    #1 last_wr_cyc = cyc;
    @(negedge clk);
    r_psel = 1'b0; r_penable = 1'b0; r_pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [4:0] a, output logic [31:0] d, output logic err);
    r_paddr = {15'b0, a}; r_pwrite = 1'b0; r_psel = 1'b1; r_penable = 1'b0;
    @(negedge clk);
    r_penable = 1'b1;
    #1 d = w_prdata; err = w_pslverr;
    @(posedge clk);
    @(negedge clk);
    r_psel = 1'b0; r_penable = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!w_op_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!w_op_done) chk({tag, " done_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic run_job(input string tag, input logic [1:0] mode, input logic [1:0] w,
                         input logic [31:0] d, input logic [31:0] nz,
                         input logic [31:0] exp_d, input logic [1:0] exp_e);
    logic        e;
    logic [31:0] rd;
    apb_wr(5'h04, d, e);
    apb_wr(5'h08, {30'b0, w}, e);
    apb_wr(5'h0C, nz, e);
    apb_wr(5'h00, {30'b0, mode}, e);
    chk({tag, " ctrl_slverr"}, 64'(e), 64'd0);
    wait_done(tag);
    chk({tag, " latency"}, 64'(cyc - last_wr_cyc), 64'd4);
    @(negedge clk);
    chk({tag, " done_pulse"}, 64'(w_op_done), 64'd0);
    chk({tag, " data_out"}, 64'(w_data_out), 64'(exp_d));
    chk({tag, " num_err"}, 64'(w_nerr), 64'(exp_e));
    apb_rd(5'h18, rd, e);
    chk({tag, " res_err"}, 64'(rd), 64'(exp_e));
    apb_rd(5'h14, rd, e);
    chk({tag, " res_data"}, 64'(rd), 64'(exp_d));
  endtask

  initial begin
    logic        e;
    logic [31:0] rd;

    repeat (3) @(negedge clk);
    chk("rst data_out", 64'(w_data_out), 64'd0);
    chk("rst op_done", 64'(w_op_done), 64'd0);
    chk("rst irq", 64'(w_irq), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    apb_rd(5'h10, rd, e);
    chk("rst status", 64'(rd), 64'h4);

    run_job("enc w0 0xB",    2'd0, 2'd0, 32'hB,   32'h0,        32'h55,       2'd0);
    run_job("chan nz04",     2'd2, 2'd0, 32'hB,   32'h04,       32'hB,        2'd1);
    run_job("chan nz80",     2'd2, 2'd0, 32'hB,   32'h80,       32'hB,        2'd1);
    run_job("chan nz03",     2'd2, 2'd0, 32'hB,   32'h03,       32'hB,        2'd2);
    run_job("dec 0x55",      2'd1, 2'd0, 32'h55,  32'h0,        32'hB,        2'd0);
    run_job("dec 0x155",     2'd1, 2'd0, 32'h155, 32'h0,        32'hB,        2'd0);
    run_job("enc w1 1",      2'd0, 2'd1, 32'h1,   32'h0,        32'h8007,     2'd0);
    run_job("enc w2 1",      2'd0, 2'd2, 32'h1,   32'h0,        32'h8000_0007, 2'd0);
    run_job("chan w2 pos31", 2'd2, 2'd2, 32'h1,   32'h4000_0000, 32'h1,       2'd1);
    run_job("dec w2 clean",  2'd1, 2'd2, 32'h8000_0007, 32'h0,  32'h1,        2'd0);

    apb_wr(5'h00, 32'h3, e);
    chk("mode3 slverr", 64'(e), 64'd1);
    apb_wr(5'h08, 32'h3, e);
    apb_rd(5'h08, rd, e);
    chk("width readback", 64'(rd), 64'd3);
    apb_wr(5'h00, 32'h0, e);
    chk("width3 slverr", 64'(e), 64'd1);
    apb_wr(5'h08, 32'h0, e);
    apb_rd(5'h02, rd, e);
    chk("misaligned slverr", 64'(e), 64'd1);
    chk("misaligned prdata", 64'(rd), 64'd0);
    apb_rd(5'h14, rd, e);
    chk("empty pop slverr", 64'(e), 64'd1);
    chk("empty pop prdata", 64'(rd), 64'd0);
    repeat (6) @(negedge clk);
    apb_rd(5'h10, rd, e);
    chk("dropped jobs status", 64'(rd), 64'h4);

    // Fill the result FIFO, then the job FIFO behind the stalled engine.
    apb_wr(5'h0C, 32'h0, e);
    for (int k = 1; k <= 4; k++) begin
      apb_wr(5'h04, 32'(k), e);
      apb_wr(5'h00, 32'h2, e);
      chk($sformatf("q push%0d", k), 64'(e), 64'd0);
    end
    repeat (30) @(negedge clk);
    apb_rd(5'h10, rd, e);
    chk("q res full status", 64'(rd), 64'h0004_000C);
    for (int k = 5; k <= 8; k++) begin
      apb_wr(5'h04, 32'(k), e);
      apb_wr(5'h00, 32'h2, e);
      chk($sformatf("q push%0d", k), 64'(e), 64'd0);
    end
    apb_wr(5'h04, 32'h9, e);
    apb_wr(5'h00, 32'h2, e);
    chk("q push9 full slverr", 64'(e), 64'd1);
    repeat (10) @(negedge clk);
    apb_rd(5'h10, rd, e);
    chk("q both full status", 64'(rd), 64'h0004_040A);
    apb_rd(5'h14, rd, e);
    chk("q pop1", 64'(rd), 64'd1);
    wait_done("q job5");
    chk("q job5 data_out", 64'(w_data_out), 64'd5);
    for (int k = 2; k <= 8; k++) begin
      apb_rd(5'h14, rd, e);
      chk($sformatf("q pop%0d", k), 64'(rd), 64'(k));
      repeat (8) @(negedge clk);
    end
    apb_rd(5'h14, rd, e);
    chk("q drained slverr", 64'(e), 64'd1);
    apb_rd(5'h10, rd, e);
    chk("q drained status", 64'(rd), 64'h4);

    apb_wr(5'h1C, 32'h1, e);
    run_job("irq job", 2'd0, 2'd0, 32'hB, 32'h0, 32'h55, 2'd0);
    chk("irq set", 64'(w_irq), 64'd1);
    apb_rd(5'h1C, rd, e);
    chk("irq reg", 64'(rd), 64'h3);
    apb_wr(5'h1C, 32'h3, e);
    chk("irq w1c", 64'(w_irq), 64'd0);
    apb_rd(5'h10, rd, e);
    chk("irq cleared status", 64'(rd), 64'h4);
    run_job("irq job2", 2'd1, 2'd0, 32'h55, 32'h0, 32'hB, 2'd0);
    chk("irq set again", 64'(w_irq), 64'd1);

    apb_wr(5'h04, 32'h7, e);
    apb_wr(5'h00, 32'h0, e);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midexec data_out", 64'(w_data_out), 64'd0);
    chk("midexec num_err", 64'(w_nerr), 64'd0);
    chk("midexec irq", 64'(w_irq), 64'd0);
    chk("midexec op_done", 64'(w_op_done), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    chk("post rst data_out", 64'(w_data_out), 64'd0);
    apb_rd(5'h10, rd, e);
    chk("post rst status", 64'(rd), 64'h4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
